// File: rtl/can_pkg.sv
// CAN 2.0A constants, transmit state encoding and stuffing-region helper.
package can_pkg;

   localparam logic [14:0] CAN_CRC_POLY    = 15'h4599;
   localparam int          CAN_ID_W        = 11;
   localparam int          CAN_DLC_W       = 4;
   localparam int          CAN_CRC_W       = 15;
   localparam int          CAN_EOF_LEN     = 7;
   localparam int          CAN_IFS_LEN     = 3;
   localparam int          CAN_STUFF_LIMIT = 5;

   typedef enum logic [3:0] {
      S_IDLE,
      S_SOF,
      S_ARB,
      S_CTRL,
      S_DATA,
      S_CRC,
      S_CRC_DELIM,
      S_ACK,
      S_ACK_DELIM,
      S_EOF,
      S_IFS
   } can_tx_state_t;

   // SOF through the last CRC bit is subject to bit stuffing.
   function automatic logic is_stuffed(can_tx_state_t s);
      return s inside {S_SOF, S_ARB, S_CTRL, S_DATA, S_CRC};
   endfunction

endpackage

// File: rtl/can_crc15.sv
// Serial CAN CRC-15 accumulator, shared by transmitter and receiver.
module can_crc15
   import can_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 enable,
   input  logic                 data_bit,
   output logic [CAN_CRC_W-1:0] crc
);

   logic fb;

   assign fb = data_bit ^ crc[CAN_CRC_W-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         crc <= '0;
      else if (clear)
         crc <= '0;
      else if (enable)
         crc <= {crc[CAN_CRC_W-2:0], 1'b0} ^ (fb ? CAN_CRC_POLY : '0);
   end

endmodule

// File: rtl/can_frame_tx.sv
// CAN 2.0A standard data frame transmitter: CRC-15, bit stuffing, trailer.
module can_frame_tx
   import can_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic        i_Clock,
   input  logic        i_Reset,
   input  logic        i_Tx_DV,
   input  logic [10:0] i_Identifier,
   input  logic [3:0]  i_DLC,
   input  logic [63:0] i_Data,
   output logic        o_Tx_Serial,
   output logic        o_Tx_Active,
   output logic        o_Tx_Done
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);

   can_tx_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [5:0]  idx_q, idx_d;
   logic [2:0]  trl_q, trl_d;
   logic [2:0]  run_q, run_d;
   logic        stuff_q, stuff_d;
   logic        serial_q, serial_d;
   logic        active_q, active_d;
   logic        done_q, done_d;

   logic [10:0] id_q;
   logic [3:0]  dlc_q;
   logic [63:0] data_q;
   logic [3:0]  nb;
   logic [18:0] hdr;
   logic        data_last;

   logic        latch;
   logic        bit_end;
   logic        bit_v;
   logic        crc_clr;
   logic        crc_en;
   logic [14:0] crc;

   assign nb        = (dlc_q > 4'd8) ? 4'd8 : dlc_q;
   assign hdr       = {1'b0, id_q, 3'b000, dlc_q};
   assign data_last = ({1'b0, idx_q} == ({nb, 3'b000} - 7'd1));
   assign bit_end   = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

   can_crc15 u_crc (
      .clk      (i_Clock),
      .rst      (i_Reset),
      .clear    (crc_clr),
      .enable   (crc_en),
      .data_bit (bit_v),
      .crc      (crc)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      trl_d    = trl_q;
      run_d    = run_q;
      stuff_d  = stuff_q;
      serial_d = serial_q;
      active_d = active_q;
      done_d   = 1'b0;
      latch    = 1'b0;
      crc_clr  = 1'b0;
      crc_en   = 1'b0;
      bit_v    = 1'b1;

      if (state_q == S_IDLE) begin
         if (i_Tx_DV) begin
            latch    = 1'b1;
            crc_clr  = 1'b1;
            state_d  = S_SOF;
            cnt_d    = '0;
            idx_d    = '0;
            trl_d    = '0;
            run_d    = 3'd1;
            stuff_d  = 1'b0;
            serial_d = 1'b0;
            active_d = 1'b1;
         end
      end else if (!bit_end) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!stuff_q && is_stuffed(state_q) &&
                   run_q == 3'(CAN_STUFF_LIMIT)) begin
         // Stuff bit holds the field position; it starts a new run.
         cnt_d    = '0;
         stuff_d  = 1'b1;
         serial_d = ~serial_q;
         run_d    = 3'd1;
      end else begin
         cnt_d   = '0;
         stuff_d = 1'b0;
         unique case (state_q)
            S_SOF: begin
               state_d = S_ARB;
               idx_d   = '0;
            end
            S_ARB: begin
               if (idx_q == 6'd11) begin
                  state_d = S_CTRL;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 6'd1;
               end
            end
            S_CTRL: begin
               idx_d = '0;
               if (idx_q == 6'd5)
                  state_d = (nb == 4'd0) ? S_CRC : S_DATA;
               else
                  idx_d = idx_q + 6'd1;
            end
            S_DATA: begin
               idx_d = '0;
               if (data_last)
                  state_d = S_CRC;
               else
                  idx_d = idx_q + 6'd1;
            end
            S_CRC: begin
               if (idx_q == 6'd14)
                  state_d = S_CRC_DELIM;
               else
                  idx_d = idx_q + 6'd1;
            end
            S_CRC_DELIM: state_d = S_ACK;
            S_ACK:       state_d = S_ACK_DELIM;
            S_ACK_DELIM: begin
               state_d = S_EOF;
               trl_d   = '0;
            end
            S_EOF: begin
               trl_d = trl_q + 3'd1;
               if (trl_q == 3'(CAN_EOF_LEN - 1)) begin
                  state_d = S_IFS;
                  trl_d   = '0;
               end
            end
            S_IFS: begin
               trl_d = trl_q + 3'd1;
               if (trl_q == 3'(CAN_IFS_LEN - 1)) begin
                  state_d  = S_IDLE;
                  trl_d    = '0;
                  active_d = 1'b0;
                  done_d   = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase

         unique case (state_d)
            S_ARB:   bit_v = hdr[5'd17 - 5'(idx_d)];
            S_CTRL:  bit_v = hdr[5'd5 - 5'(idx_d)];
            S_DATA:  bit_v = data_q[~idx_d];
            S_CRC:   bit_v = crc[4'd14 - 4'(idx_d)];
            default: bit_v = 1'b1;
         endcase

         serial_d = bit_v;
         crc_en   = state_d inside {S_ARB, S_CTRL, S_DATA};
         if (is_stuffed(state_d))
            run_d = (bit_v == serial_q) ? run_q + 3'd1 : 3'd1;
      end
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         trl_q    <= '0;
         run_q    <= '0;
         stuff_q  <= 1'b0;
         serial_q <= 1'b1;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         trl_q    <= trl_d;
         run_q    <= run_d;
         stuff_q  <= stuff_d;
         serial_q <= serial_d;
         active_q <= active_d;
         done_q   <= done_d;
      end
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         id_q   <= '0;
         dlc_q  <= '0;
         data_q <= '0;
      end else if (latch) begin
         id_q   <= i_Identifier;
         dlc_q  <= i_DLC;
         data_q <= i_Data;
      end
   end

   assign o_Tx_Serial = serial_q;
   assign o_Tx_Active = active_q;
   assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_can_frame_tx.sv
// Directed-vector bench for can_frame_tx with a serial frame reference model.
module tb_can_frame_tx;

   localparam int CPB = 10;

   logic        i_Clock = 1'b0;
   logic        i_Reset;
   logic        i_Tx_DV;
   logic [10:0] i_Identifier;
   logic [3:0]  i_DLC;
   logic [63:0] i_Data;
   logic        o_Tx_Serial;
   logic        o_Tx_Active;
   logic        o_Tx_Done;

   typedef struct {
      logic [10:0] id;
      logic [3:0]  dlc;
      logic [63:0] data;
      logic [15:0] pfx;
      int          plen;
      int          ulen;
   } vec_t;

   vec_t vecs[6];
   logic ref_u[$];
   logic ref_line[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   can_frame_tx #(.CLKS_PER_BIT(CPB)) dut (
      .i_Clock      (i_Clock),
      .i_Reset      (i_Reset),
      .i_Tx_DV      (i_Tx_DV),
      .i_Identifier (i_Identifier),
      .i_DLC        (i_DLC),
      .i_Data       (i_Data),
      .o_Tx_Serial  (o_Tx_Serial),
      .o_Tx_Active  (o_Tx_Active),
      .o_Tx_Done    (o_Tx_Done)
   );

   always #5 i_Clock = ~i_Clock;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic build_ref(input vec_t v);
      logic [14:0] c;
      logic        nxt;
      logic        last;
      int          nbytes;
      int          cnt;
      ref_u.delete();
      ref_line.delete();
      ref_u.push_back(1'b0);
      for (int i = 10; i >= 0; i--) ref_u.push_back(v.id[i]);
      repeat (3) ref_u.push_back(1'b0);
      for (int i = 3; i >= 0; i--) ref_u.push_back(v.dlc[i]);
      nbytes = (v.dlc > 4'd8) ? 8 : int'(v.dlc);
      for (int i = 63; i >= 64 - 8 * nbytes; i--) ref_u.push_back(v.data[i]);
      c = '0;
      foreach (ref_u[i]) begin
         nxt = ref_u[i] ^ c[14];
         c   = {c[13:0], 1'b0};
         if (nxt) c = c ^ 15'h4599;
      end
      for (int i = 14; i >= 0; i--) ref_u.push_back(c[i]);
      cnt  = 0;
      last = 1'b1;
      foreach (ref_u[i]) begin
         ref_line.push_back(ref_u[i]);
         if (cnt > 0 && ref_u[i] == last) cnt++;
         else cnt = 1;
         last = ref_u[i];
         if (cnt == 5) begin
            ref_line.push_back(~last);
            last = ~last;
            cnt  = 1;
         end
      end
      repeat (13) ref_line.push_back(1'b1);
   endtask

   task automatic run_frame(input string tag, input vec_t v, input int poke_at,
                            input bit started, input bit chain, input vec_t nv);
      logic        cap[$];
      logic        ds[$];
      logic        exp_bit;
      logic        b;
      logic        prev;
      logic [15:0] got_pfx;
      int          n, bad, first_bad, k, run, serr, rem, ones, mism;
      build_ref(v);
      if (!started) begin
         i_Identifier = v.id;
         i_DLC        = v.dlc;
         i_Data       = v.data;
         i_Tx_DV      = 1'b1;
         @(negedge i_Clock);
      end
      i_Tx_DV   = 1'b0;
      n         = ref_line.size() * CPB;
      bad       = 0;
      first_bad = -1;
      for (int j = 0; j < n; j++) begin
         exp_bit = ref_line[j / CPB];
         if (o_Tx_Serial !== exp_bit || o_Tx_Active !== 1'b1 ||
             o_Tx_Done !== 1'b0) begin
            bad++;
            if (first_bad < 0) first_bad = j;
         end
         if (j % CPB == CPB / 2) cap.push_back(o_Tx_Serial);
         if (j == poke_at) begin
            i_Identifier = ~v.id;
            i_DLC        = 4'd8;
            i_Tx_DV      = 1'b1;
         end else if (j == poke_at + 1) begin
            i_Tx_DV = 1'b0;
         end
         @(negedge i_Clock);
      end
      check($sformatf("%s wave first_bad_clk=%0d", tag, first_bad),
            64'(bad), 64'd0);
      check({tag, " done_pulse"},
            {61'd0, o_Tx_Done, o_Tx_Active, o_Tx_Serial}, 64'b101);
      if (chain) begin
         i_Identifier = nv.id;
         i_DLC        = nv.dlc;
         i_Data       = nv.data;
         i_Tx_DV      = 1'b1;
      end
      @(negedge i_Clock);
      check({tag, " done_single"}, {63'd0, o_Tx_Done}, 64'd0);
      if (chain)
         check({tag, " b2b_sof"}, {62'd0, o_Tx_Active, o_Tx_Serial}, 64'b10);

      got_pfx = '0;
      for (int i = 0; i < v.plen && i < cap.size(); i++)
         got_pfx = {got_pfx[14:0], cap[i]};
      check({tag, " prefix"}, 64'(got_pfx), 64'(v.pfx));

      k    = 0;
      run  = 0;
      prev = 1'b1;
      serr = 0;
      while (k < cap.size() && ds.size() < v.ulen) begin
         b = cap[k];
         k++;
         ds.push_back(b);
         run  = (run > 0 && b == prev) ? run + 1 : 1;
         prev = b;
         if (run == 5 && k < cap.size()) begin
            if (cap[k] == prev) serr++;
            prev = cap[k];
            k++;
            run = 1;
         end
      end
      check({tag, " stuff_polarity"}, 64'(serr), 64'd0);
      check({tag, " destuffed_len"}, 64'(ds.size()), 64'(v.ulen));
      mism = 0;
      foreach (ds[i])
         if (i >= ref_u.size() || ds[i] !== ref_u[i]) mism++;
      check({tag, " destuffed_bits"}, 64'(mism), 64'd0);
      rem  = cap.size() - k;
      ones = 0;
      for (int i = k; i < cap.size(); i++)
         if (cap[i]) ones++;
      check({tag, " trailer_len"}, 64'(rem), 64'd13);
      check({tag, " trailer_ones"}, 64'(ones), 64'd13);
   endtask

   initial begin
      int bad;
      i_Reset      = 1'b1;
      i_Tx_DV      = 1'b0;
      i_Identifier = '0;
      i_DLC        = '0;
      i_Data       = '0;

      vecs[0] = '{11'h000, 4'h0, 64'h0, 16'h0002, 7, 34};
      vecs[1] = '{11'h7FF, 4'h0, 64'h0, 16'h007D, 8, 34};
      vecs[2] = '{11'h014, 4'h1, 64'h5500_0000_0000_0000, 16'h04A0, 16, 42};
      vecs[3] = '{11'h555, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 16'h5551, 16, 98};
      vecs[4] = '{11'h123, 4'h8, 64'h0123_4567_89AB_CDEF, 16'h1231, 16, 98};
      vecs[5] = '{11'h2AA, 4'h9, 64'hA5A5_A5A5_A5A5_A5A5, 16'h2AA1, 16, 98};

      repeat (3) @(negedge i_Clock);
      check("reset_outputs", {61'd0, o_Tx_Serial, o_Tx_Active, o_Tx_Done},
            64'b100);
      i_Reset = 1'b0;
      repeat (2) @(negedge i_Clock);
      check("idle_outputs", {61'd0, o_Tx_Serial, o_Tx_Active, o_Tx_Done},
            64'b100);

      for (int i = 0; i < 6; i++)
         run_frame($sformatf("vec%0d", i), vecs[i], -1, 1'b0, 1'b0, vecs[i]);

      run_frame("poke", vecs[0], 200, 1'b0, 1'b1, vecs[2]);
      run_frame("chained", vecs[2], -1, 1'b1, 1'b0, vecs[2]);

      i_Identifier = vecs[3].id;
      i_DLC        = vecs[3].dlc;
      i_Data       = vecs[3].data;
      i_Tx_DV      = 1'b1;
      @(negedge i_Clock);
      i_Tx_DV = 1'b0;
      repeat (400) @(negedge i_Clock);
      check("mid_active", {63'd0, o_Tx_Active}, 64'd1);
      #2 i_Reset = 1'b1;
      #1;
      check("async_reset", {62'd0, o_Tx_Serial, o_Tx_Active}, 64'b10);
      @(negedge i_Clock);
      i_Reset = 1'b0;
      bad = 0;
      repeat (50) begin
         @(negedge i_Clock);
         if (o_Tx_Done !== 1'b0 || o_Tx_Serial !== 1'b1 ||
             o_Tx_Active !== 1'b0)
            bad++;
      end
      check("post_reset_quiet", 64'(bad), 64'd0);
      run_frame("after_reset", vecs[4], -1, 1'b0, 1'b0, vecs[4]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
